scr1_ahb_mem_slave: RTL and testbench

AHB-Lite responder that serves single transfers from an AHB master, such as the core's data or instruction bridge, out of a synchronous single-port SRAM. It decodes the address phase and generates byte enables. It inserts programmable wait states and returns OKAY/ERROR responses using the standard two-cycle AHB ERROR sequence. It sits behind the AHB interconnect as a TCM/scratchpad target.

---
 rtl/scr1_ahb_mem_slave_pkg.sv | 27 ++
 rtl/scr1_ahb_be_decode.sv | 32 +++
 rtl/scr1_ahb_mem_slave.sv | 139 +++++++++++++
 tb/tb_scr1_ahb_mem_slave.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_ahb_mem_slave_pkg.sv
// Shared AHB-Lite definitions: HTRANS/HSIZE/HRESP encodings and the state type
// used by the AHB memory responder FSM.
package scr1_ahb_mem_slave_pkg;

  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SCR1_HSIZE_8B  = 3'b000;
  localparam logic [2:0] SCR1_HSIZE_16B = 3'b001;
  localparam logic [2:0] SCR1_HSIZE_32B = 3'b010;

  localparam logic SCR1_HRESP_OKAY  = 1'b0;
  localparam logic SCR1_HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StWr,
    StRdReq,
    StRdData,
    StErr1,
    StErr2
  } type_scr1_ahbslv_fsm_e;

endpackage

// File: rtl/scr1_ahb_be_decode.sv
// Byte-enable and alignment decoder for 32-bit AHB slaves.
//   size_i     : HSIZE of the transfer
//   addr_i     : low two address bits
//   be_o       : byte-lane enables (all zero for sizes wider than a word)
//   misalign_o : address not naturally aligned for the given size
module scr1_ahb_be_decode
  import scr1_ahb_mem_slave_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] be_o,
  output logic       misalign_o
);

  always_comb begin
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    case (size_i)
      SCR1_HSIZE_8B: be_o = 4'b0001 << addr_i;
      SCR1_HSIZE_16B: begin
        be_o       = 4'b0011 << {addr_i[1], 1'b0};
        misalign_o = addr_i[0];
      end
      SCR1_HSIZE_32B: begin
        be_o       = 4'b1111;
        misalign_o = |addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/scr1_ahb_mem_slave.sv
// AHB-Lite responder serving single transfers from a synchronous single-port SRAM.
//   clk, rst            : clock, asynchronous active-high reset
//   hsel..hready        : AHB address/data phase inputs
//   hreadyout/hresp     : slave ready and OKAY/ERROR response
//   hrdata              : read data (zero outside the read data cycle)
//   mem_*               : SRAM request port; mem_rdata valid the cycle after a read
module scr1_ahb_mem_slave
  import scr1_ahb_mem_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_AWIDTH  = 14,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [31:0]           haddr,
  input  logic                  hwrite,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_AWIDTH-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [2:0] WaitLast = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  type_scr1_ahbslv_fsm_e state_q;
  logic [2:0]            cnt_q;
  logic [MEM_AWIDTH-3:0] addr_q;
  logic [3:0]            be_q;
  logic                  write_q;

  logic                  accept;
  logic                  req_err;
  logic [3:0]            be;
  logic                  misalign;
  type_scr1_ahbslv_fsm_e start_state;

  scr1_ahb_be_decode u_be_decode (
    .size_i     (hsize),
    .addr_i     (haddr[1:0]),
    .be_o       (be),
    .misalign_o (misalign)
  );

  // Entry state of a freshly accepted transfer.
  always_comb begin
    accept  = hsel & hready & ((htrans == SCR1_HTRANS_NONSEQ) | (htrans == SCR1_HTRANS_SEQ));
    req_err = ((haddr >> MEM_AWIDTH) != (BASE_ADDR >> MEM_AWIDTH))
            | (hsize > SCR1_HSIZE_32B) | misalign;
    if (req_err) begin
      start_state = StErr1;
    end else if (WAIT_STATES != 0) begin
      start_state = StWait;
    end else if (hwrite) begin
      start_state = StWr;
    end else begin
      start_state = StRdReq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      write_q <= 1'b0;
    end else begin
      unique case (state_q)
        // Ready states: the bus may hand over the next address phase here.
        StIdle, StWr, StRdData, StErr2: begin
          if (accept) begin
            state_q <= start_state;
            addr_q  <= haddr[MEM_AWIDTH-1:2];
            be_q    <= be;
            write_q <= hwrite;
            cnt_q   <= 3'd0;
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (cnt_q == WaitLast) begin
            cnt_q   <= 3'd0;
            state_q <= write_q ? StWr : StRdReq;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StRdReq: state_q <= StRdData;
        StErr1:  state_q <= StErr2;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode from the state register only, so reset clears them at once.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = SCR1_HRESP_OKAY;
    hrdata    = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      StWait: hreadyout = 1'b0;
      StWr: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = hwdata;
      end
      StRdReq: begin
        hreadyout = 1'b0;
        mem_req   = 1'b1;
      end
      StRdData: hrdata = mem_rdata;
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = SCR1_HRESP_ERROR;
      end
      StErr2: hresp = SCR1_HRESP_ERROR;
      default: ;
    endcase
  end

  assign mem_addr = addr_q;
  assign mem_be   = be_q;

endmodule

// File: tb/tb_scr1_ahb_mem_slave.sv
// Bench: two responders (0 and 3 wait states) on a shared stimulus bus, each with its
// own SRAM model. A pipelined master pushes expected responses into a scoreboard;
// a monitor pops and compares when each data phase completes.
module tb_scr1_ahb_mem_slave;
  import scr1_ahb_mem_slave_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        dsel = 1'b0;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = SCR1_HTRANS_IDLE;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;

  logic        ho  [2];
  logic        hr  [2];
  logic [31:0] hrd [2];
  logic        mq  [2];
  logic        mw  [2];
  logic [11:0] ma  [2];
  logic [3:0]  mbe [2];
  logic [31:0] mwd [2];
  logic [31:0] mrd [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [4096];

    scr1_ahb_mem_slave #(
      .BASE_ADDR   (32'h0000_0000),
      .MEM_AWIDTH  (14),
      .WAIT_STATES (g * 3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .hsel      (hsel & (dsel == 1'(g))),
      .htrans    (htrans),
      .hsize     (hsize),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .hwdata    (hwdata),
      .hready    (ho[g]),
      .hreadyout (ho[g]),
      .hresp     (hr[g]),
      .hrdata    (hrd[g]),
      .mem_req   (mq[g]),
      .mem_we    (mw[g]),
      .mem_addr  (ma[g]),
      .mem_be    (mbe[g]),
      .mem_wdata (mwd[g]),
      .mem_rdata (mrd[g])
    );

    always @(posedge clk) begin
      if (mq[g]) begin
        if (mw[g]) begin
          for (int b = 0; b < 4; b++) begin
            if (mbe[g][b]) mem[ma[g]][b*8 +: 8] <= mwd[g][b*8 +: 8];
          end
        end else begin
          mrd[g] <= mem[ma[g]];
        end
      end
    end
  end

  logic        s_ready, s_resp, s_req, s_we;
  logic [31:0] s_rdata, s_wdata;
  logic [11:0] s_maddr;
  logic [3:0]  s_be;
  always_comb begin
    s_ready = ho[dsel];
    s_resp  = hr[dsel];
    s_rdata = hrd[dsel];
    s_req   = mq[dsel];
    s_we    = mw[dsel];
    s_maddr = ma[dsel];
    s_be    = mbe[dsel];
    s_wdata = mwd[dsel];
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] rdata;
    int          waits;
    logic [11:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    exp_t        e;
  } xfer_t;

  exp_t  sb[$];
  xfer_t pend[$];

  task automatic q_xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic err, input int waits,
                        input logic [3:0] be, input logic [31:0] rd);
    xfer_t x;
    x.wr = wr; x.size = sz; x.addr = a; x.wdata = wr ? wd : 32'h0;
    x.e.rd = !wr; x.e.err = err; x.e.rdata = rd; x.e.waits = waits;
    x.e.maddr = a[13:2]; x.e.be = be; x.e.wd = wd;
    pend.push_back(x);
  endtask

  // Pipelined master: a new address phase is presented after each ready cycle.
  task automatic run();
    logic        rdy;
    logic [31:0] ap_wdata = '0;
    int          budget = 200;
    xfer_t       x;
    while ((pend.size() > 0 || sb.size() > 0) && budget > 0) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        hwdata = ap_wdata;
        if (pend.size() > 0) begin
          x = pend.pop_front();
          hsel = 1'b1; htrans = SCR1_HTRANS_NONSEQ;
          hsize = x.size; haddr = x.addr; hwrite = x.wr;
          ap_wdata = x.wdata;
          sb.push_back(x.e);
        end else begin
          hsel = 1'b0; htrans = SCR1_HTRANS_IDLE; ap_wdata = '0;
        end
      end
      budget--;
    end
    if (budget == 0) begin
      total++;
      $display("FAIL run_timeout: got %0d pending, required 0", sb.size() + pend.size());
      sb.delete();
      pend.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Monitor: tracks the current data phase and scores it on completion.
  initial begin
    logic        in_dp = 1'b0;
    int          lows = 0, err_lows = 0, reqs = 0;
    logic [11:0] ra = '0;
    logic [3:0]  rb = '0;
    logic [31:0] rw = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_dp = 1'b0;
        continue;
      end
      if (in_dp) begin
        if (s_req) begin
          reqs++; ra = s_maddr; rb = s_be; rw = s_wdata;
        end
        if (!s_ready) begin
          lows++;
          if (s_resp) err_lows++;
        end else begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_empty: got completion, required none");
          end else begin
            e = sb.pop_front();
            check("hresp", 32'(s_resp), 32'(e.err));
            check("wait_cycles", lows, e.waits);
            check("mem_req_count", reqs, e.err ? 0 : 1);
            if (e.err) begin
              check("err1_hresp", err_lows, 1);
            end else begin
              check("mem_addr", 32'(ra), 32'(e.maddr));
              check("mem_be", 32'(rb), 32'(e.be));
              if (e.rd) check("hrdata", s_rdata, e.rdata);
              else check("mem_wdata", rw, e.wd);
            end
          end
          in_dp = 1'b0;
        end
      end
      if (s_ready) begin
        in_dp = hsel & htrans[1];
        lows = 0; err_lows = 0; reqs = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hreadyout", 32'(s_ready), 32'd1);
    check("rst_hresp", 32'(s_resp), 32'd0);
    check("rst_hrdata", s_rdata, 32'h0);
    check("rst_mem_req", 32'(s_req), 32'd0);
    check("rst_mem_we", 32'(s_we), 32'd0);

    // Zero-wait instance: word, byte, halfword traffic and error sequences.
    dsel = 1'b0;
    q_xfer(1, SCR1_HSIZE_32B, 32'h10, 32'hDEADBEEF, 0, 0, 4'hF, 0);
    q_xfer(0, SCR1_HSIZE_32B, 32'h10, 0, 0, 1, 4'hF, 32'hDEADBEEF);
    q_xfer(1, SCR1_HSIZE_8B, 32'h13, 32'hAA000000, 0, 0, 4'b1000, 0);
    q_xfer(0, SCR1_HSIZE_32B, 32'h10, 0, 0, 1, 4'hF, 32'hAAADBEEF);
    q_xfer(0, SCR1_HSIZE_32B, 32'h4000, 0, 1, 1, 4'h0, 0);
    q_xfer(1, SCR1_HSIZE_16B, 32'h1, 32'h1111, 1, 1, 4'h0, 0);
    q_xfer(1, SCR1_HSIZE_32B, 32'h20, 32'h12345678, 0, 0, 4'hF, 0);
    q_xfer(0, 3'b011, 32'h0, 0, 1, 1, 4'h0, 0);
    q_xfer(1, SCR1_HSIZE_16B, 32'h22, 32'hBEEF0000, 0, 0, 4'b1100, 0);
    q_xfer(1, SCR1_HSIZE_8B, 32'h21, 32'h00009900, 0, 0, 4'b0010, 0);
    q_xfer(0, SCR1_HSIZE_32B, 32'h20, 0, 0, 1, 4'hF, 32'hBEEF9978);
    run();

    // Three-wait instance: back-to-back write, read, write, read to one word.
    dsel = 1'b1;
    q_xfer(1, SCR1_HSIZE_32B, 32'h40, 32'hCAFEF00D, 0, 3, 4'hF, 0);
    q_xfer(0, SCR1_HSIZE_32B, 32'h40, 0, 0, 4, 4'hF, 32'hCAFEF00D);
    q_xfer(1, SCR1_HSIZE_32B, 32'h40, 32'h01020304, 0, 3, 4'hF, 0);
    q_xfer(0, SCR1_HSIZE_32B, 32'h40, 0, 0, 4, 4'hF, 32'h01020304);
    run();

    // Reset asserted while the read sits in its SRAM request cycle.
    dsel = 1'b0;
    @(posedge clk);
    #1;
    hsel = 1'b1; htrans = SCR1_HTRANS_NONSEQ; hsize = SCR1_HSIZE_32B;
    haddr = 32'h10; hwrite = 1'b0;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = SCR1_HTRANS_IDLE;
    check("rdreq_hreadyout", 32'(s_ready), 32'd0);
    check("rdreq_mem_req", 32'(s_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_hreadyout", 32'(s_ready), 32'd1);
    check("arst_hresp", 32'(s_resp), 32'd0);
    check("arst_mem_req", 32'(s_req), 32'd0);
    check("arst_hrdata", s_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_hreadyout", 32'(s_ready), 32'd1);
    check("post_rst_mem_req", 32'(s_req), 32'd0);
    q_xfer(0, SCR1_HSIZE_32B, 32'h10, 0, 0, 1, 4'hF, 32'hAAADBEEF);
    run();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
